ycr1_tcm_portb_arb: RTL

YCR1_TCM_PORTB_ARB -- requirements
Module: ycr1_tcm_portb_arb

---
 rtl/ycr1_tcm_portb_arb.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/ycr1_tcm_portb_arb.sv
// TCM port-B arbiter: shares one memory port between the core data port and
// the loader, alternating priority on contention, with a one-cycle response.
module ycr1_tcm_portb_arb #(
    parameter int YCR1_WIDTH  = 32,
    parameter int YCR1_NBYTES = YCR1_WIDTH / 8,
    parameter int YCR1_AWIDTH = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   core_req,
    input  logic                   core_we,
    input  logic [YCR1_NBYTES-1:0] core_be,
    input  logic [YCR1_AWIDTH-1:0] core_addr,
    input  logic [YCR1_WIDTH-1:0]  core_wdata,
    input  logic                   ldr_req,
    input  logic                   ldr_we,
    input  logic [YCR1_NBYTES-1:0] ldr_be,
    input  logic [YCR1_AWIDTH-1:0] ldr_addr,
    input  logic [YCR1_WIDTH-1:0]  ldr_wdata,
    input  logic                   ldr_en,
    output logic                   core_gnt,
    output logic                   ldr_gnt,
    output logic                   core_resp,
    output logic                   ldr_resp,
    output logic [YCR1_WIDTH-1:0]  core_rdata,
    output logic [YCR1_WIDTH-1:0]  ldr_rdata,
    output logic                   renb,
    output logic                   wenb,
    output logic [YCR1_NBYTES-1:0] webb,
    output logic [YCR1_AWIDTH-1:0] addrb,
    output logic [YCR1_WIDTH-1:0]  datab,
    input  logic [YCR1_WIDTH-1:0]  qb
);

    logic core_vld;
    logic ldr_vld;
    logic last_ldr_q, last_ldr_d;
    logic tag_core_q, tag_core_d;
    logic tag_ldr_q, tag_ldr_d;
    logic tag_rd_q, tag_rd_d;

    // Grant selection; a disabled loader counts as absent
    always_comb begin
        core_vld = core_req & ~rst;
        ldr_vld  = ldr_req & ldr_en & ~rst;
        core_gnt = 1'b0;
        ldr_gnt  = 1'b0;
        if (core_vld && ldr_vld) begin
            if (last_ldr_q) begin
                core_gnt = 1'b1;
            end else begin
                ldr_gnt = 1'b1;
            end
        end else if (core_vld) begin
            core_gnt = 1'b1;
        end else if (ldr_vld) begin
            ldr_gnt = 1'b1;
        end else begin
            core_gnt = 1'b0;
            ldr_gnt  = 1'b0;
        end
    end

    // Memory port B driven by the winner, all zero when idle
    always_comb begin
        renb  = 1'b0;
        wenb  = 1'b0;
        webb  = '0;
        addrb = '0;
        datab = '0;
        if (core_gnt) begin
            renb  = ~core_we;
            wenb  = core_we;
            webb  = core_we ? core_be : '0;
            addrb = core_addr;
            datab = core_wdata;
        end else if (ldr_gnt) begin
            renb  = ~ldr_we;
            wenb  = ldr_we;
            webb  = ldr_we ? ldr_be : '0;
            addrb = ldr_addr;
            datab = ldr_wdata;
        end else begin
            renb  = 1'b0;
            wenb  = 1'b0;
        end
    end

    // Next arbitration state and response tag
    always_comb begin
        last_ldr_d = last_ldr_q;
        if (core_gnt) begin
            last_ldr_d = 1'b0;
        end else if (ldr_gnt) begin
            last_ldr_d = 1'b1;
        end else begin
            last_ldr_d = last_ldr_q;
        end
        tag_core_d = core_gnt;
        tag_ldr_d  = ldr_gnt;
        if (core_gnt) begin
            tag_rd_d = ~core_we;
        end else if (ldr_gnt) begin
            tag_rd_d = ~ldr_we;
        end else begin
            tag_rd_d = 1'b0;
        end
    end

    // State registers; reset leaves the loader as last winner
    always_ff @(posedge clk) begin
        if (rst) begin
            last_ldr_q <= 1'b1;
            tag_core_q <= 1'b0;
            tag_ldr_q  <= 1'b0;
            tag_rd_q   <= 1'b0;
        end else begin
            last_ldr_q <= last_ldr_d;
            tag_core_q <= tag_core_d;
            tag_ldr_q  <= tag_ldr_d;
            tag_rd_q   <= tag_rd_d;
        end
    end

    // Responses; read data only qualifies a read response
    always_comb begin
        core_resp = tag_core_q & ~rst;
        ldr_resp  = tag_ldr_q & ~rst;
        if (core_resp && tag_rd_q) begin
            core_rdata = qb;
        end else begin
            core_rdata = '0;
        end
        if (ldr_resp && tag_rd_q) begin
            ldr_rdata = qb;
        end else begin
            ldr_rdata = '0;
        end
    end

endmodule
